// File: rtl/nand_page_read_out.sv
// NAND page read-out: waits out tR on R/B#, strobes RE# once per byte and hands each
// captured byte to a one-entry valid/ready output register.
module nand_page_read_out #(
    parameter int unsigned PAGE_BYTES  = 2048,
    parameter int unsigned RE_LOW_CYC  = 2,
    parameter int unsigned RE_HIGH_CYC = 1,
    parameter int unsigned TWB_CYC     = 4,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              rb_n,
    input  logic [7:0]                        IOin,
    output logic                              CEx,
    output logic                              REx,
    output logic [7:0]                        data_out,
    output logic                              data_valid,
    input  logic                              data_ready,
    output logic [$clog2(PAGE_BYTES+1)-1:0]   byte_cnt,
    output logic                              busy,
    output logic                              done,
    output logic                              error
);

    localparam int unsigned BCW = $clog2(PAGE_BYTES + 1);

    localparam logic [15:0]    TWB_LAST  = 16'(TWB_CYC - 1);
    localparam logic [15:0]    TO_LAST   = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0]    RL_LAST   = 16'(RE_LOW_CYC - 1);
    localparam logic [15:0]    RH_LAST   = 16'(RE_HIGH_CYC - 1);
    localparam logic [BCW-1:0] PAGE_FULL = BCW'(PAGE_BYTES);

    typedef enum logic [2:0] {
        StIdle, StWaitBusy, StWaitReady, StReLow, StReHigh, StStall, StDrain, StDone
    } state_e;

    state_e         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           rb_meta_q, rb_sync_q;
    logic           cex_q, rex_q, busy_q, done_q, error_q;
    logic [7:0]     data_out_q;
    logic           data_valid_q;
    logic [BCW-1:0] byte_cnt_q;

    logic accept, capture, start_acc, set_err, ce_off_d;

    assign accept = data_valid_q & data_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        start_acc = 1'b0;
        set_err   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StWaitBusy;
                    cnt_d     = '0;
                    start_acc = 1'b1;
                end
            end
            StWaitBusy: begin
                // Not seeing R/B# fall within tWB means the page was already cached.
                if (!rb_sync_q || cnt_q == TWB_LAST) begin
                    state_d = StWaitReady;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StWaitReady: begin
                if (rb_sync_q) begin
                    state_d = StReLow;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = StIdle;
                    set_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StReLow: begin
                if (cnt_q == RL_LAST) begin
                    capture = 1'b1;
                    state_d = StReHigh;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StReHigh: begin
                if (cnt_q == RH_LAST) begin
                    cnt_d = '0;
                    if (byte_cnt_q == PAGE_FULL) begin
                        state_d = StDrain;
                    end else if (data_valid_q && !data_ready) begin
                        state_d = StStall;
                    end else begin
                        state_d = StReLow;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StStall: begin
                if (accept) state_d = StReLow;
            end
            StDrain: begin
                if (!data_valid_q || data_ready) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        ce_off_d = (state_d == StIdle) || (state_d == StDone);
    end

    // Strobes and status come straight from flops so the flash pins never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            rb_meta_q    <= 1'b1;
            rb_sync_q    <= 1'b1;
            cex_q        <= 1'b1;
            rex_q        <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            byte_cnt_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rb_meta_q <= rb_n;
            rb_sync_q <= rb_meta_q;
            cex_q     <= ce_off_d;
            rex_q     <= (state_d != StReLow);
            busy_q    <= !ce_off_d;
            done_q    <= (state_d == StDone);
            if (capture) begin
                data_out_q   <= IOin;
                data_valid_q <= 1'b1;
                byte_cnt_q   <= byte_cnt_q + BCW'(1);
            end else if (accept) begin
                data_valid_q <= 1'b0;
            end
            if (start_acc) begin
                byte_cnt_q <= '0;
                error_q    <= 1'b0;
            end else if (set_err) begin
                error_q <= 1'b1;
            end
        end
    end

    assign CEx        = cex_q;
    assign REx        = rex_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_nand_page_read_out.sv
// Bench for nand_page_read_out: behavioural flash plus consumer, scenario table, random runs
// and a mid-read reset sequence.
module tb_nand_page_read_out;

    localparam int unsigned PB  = 4;
    localparam int unsigned RL  = 2;
    localparam int unsigned RH  = 1;
    localparam int unsigned TWB = 4;
    localparam int unsigned TO  = 50;

    logic       clk = 1'b0;
    logic       reset, start, rb_n, data_ready;
    logic [7:0] IOin = 8'h00;
    logic [7:0] data_out;
    logic       CEx, REx, data_valid, busy, done, error;
    logic [2:0] byte_cnt;

    always #5 clk = ~clk;

    nand_page_read_out #(
        .PAGE_BYTES (PB),
        .RE_LOW_CYC (RL),
        .RE_HIGH_CYC(RH),
        .TWB_CYC    (TWB),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rb_n      (rb_n),
        .IOin      (IOin),
        .CEx       (CEx),
        .REx       (REx),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .byte_cnt  (byte_cnt),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Flash: each RE# fall puts the next page byte on the bus.
    logic [7:0] page [PB];
    int fidx = 0;
    always @(negedge REx) begin
        IOin = (fidx < int'(PB)) ? page[fidx] : 8'h00;
        fidx++;
    end

    // Consumer-side observation, sampled mid-cycle.
    logic [7:0] got[$];
    int         acc_cyc[$];
    int         lowruns[$];
    int         lowrun = 0, done_cnt = 0, viol = 0, cyc = 0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_hold = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (data_valid && data_ready) begin
            got.push_back(data_out);
            acc_cyc.push_back(cyc);
        end
        if (!REx) lowrun++;
        else if (lowrun > 0) begin
            lowruns.push_back(lowrun);
            lowrun = 0;
        end
        if (done) done_cnt++;
        if (prev_hold && data_valid && data_out != prev_data) viol++;
        if (!REx && (CEx || data_valid)) viol++;
        if (busy && CEx) viol++;
        if (done && busy) viol++;
        prev_hold = data_valid && !data_ready;
        prev_data = data_out;
    end

    task automatic clear_mon();
        got.delete();
        acc_cyc.delete();
        lowruns.delete();
        lowrun   = 0;
        done_cnt = 0;
        viol     = 0;
    endtask

    // rb_mode: 0 falls after start, 1 never falls, 2 stuck low, 3 like 0 plus a glitch mid read.
    // rdy_mode: 0 always ready, 1 stall for 'stall' cycles after first byte, 2 random.
    typedef struct {
        int rb_mode;
        int rb_delay;
        int rb_low;
        int rdy_mode;
        int stall;
        int restart_at;
        int exp_err;
        int exp_done;
        int exp_bytes;
        int exp_first_low;
        int exp_busy_len;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int c = 0;
        int stall_left = v.stall;
        int busy_len = 0;
        int first_low = -1;
        for (int i = 0; i < int'(PB); i++) page[i] = 8'($urandom);
        @(posedge clk); #1;
        rb_n = (v.rb_mode == 2) ? 1'b0 : 1'b1;
        data_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        fidx = 0;
        clear_mon();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1;
        check($sformatf("%s err_cleared", tag), int'(error), 0);
        while (c < 600) begin
            if (busy) busy_len++;
            if (!REx && first_low < 0) first_low = c;
            if (c > 2 && !busy) break;
            case (v.rb_mode)
                0: rb_n = !(c >= v.rb_delay && c < v.rb_delay + v.rb_low);
                1: rb_n = 1'b1;
                2: rb_n = 1'b0;
                default: rb_n = !((c >= v.rb_delay && c < v.rb_delay + v.rb_low) ||
                                  (c >= v.rb_delay + v.rb_low + 8 &&
                                   c < v.rb_delay + v.rb_low + 13));
            endcase
            case (v.rdy_mode)
                0: data_ready = 1'b1;
                1: begin
                    data_ready = !(got.size() >= 1 && stall_left > 0);
                    if (!data_ready) stall_left--;
                end
                default: data_ready = 1'($urandom_range(0, 1));
            endcase
            start = (c == v.restart_at);
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("%s finished", tag), int'(c < 600), 1);
        check($sformatf("%s error", tag), int'(error), v.exp_err);
        check($sformatf("%s done_pulses", tag), done_cnt, v.exp_done);
        check($sformatf("%s bytes", tag), got.size(), v.exp_bytes);
        check($sformatf("%s re_pulses", tag), lowruns.size(), v.exp_bytes);
        check($sformatf("%s byte_cnt", tag), int'(byte_cnt), v.exp_bytes);
        check($sformatf("%s CEx_after", tag), int'(CEx), 1);
        check($sformatf("%s REx_after", tag), int'(REx), 1);
        check($sformatf("%s protocol", tag), viol, 0);
        for (int i = 0; i < got.size() && i < int'(PB); i++)
            check($sformatf("%s byte%0d", tag, i), int'(got[i]), int'(page[i]));
        for (int i = 0; i < lowruns.size(); i++)
            check($sformatf("%s re_low_len%0d", tag, i), lowruns[i], int'(RL));
        if (v.rdy_mode == 0 && v.restart_at == 0)
            for (int i = 1; i < acc_cyc.size(); i++)
                check($sformatf("%s interval%0d", tag, i), acc_cyc[i] - acc_cyc[i-1],
                      int'(RL + RH));
        if (v.exp_first_low >= 0)
            check($sformatf("%s first_re_low", tag), first_low, v.exp_first_low);
        if (v.exp_busy_len >= 0)
            check($sformatf("%s busy_len", tag), busy_len, v.exp_busy_len);
    endtask

    vec_t vecs[9];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        vec_t rv;
        int   w;
        // Normal read; first RE# fall lands after 1 tWB cycle... only the rb-held-high case is
        // timed exactly: 4 tWB cycles + 1 ready cycle, so RE# is low on cycle 6.
        vecs[0] = '{0, 1, 20, 0, 0,  0, 0, 1, 4, -1, -1};
        vecs[1] = '{0, 1, 20, 1, 10, 0, 0, 1, 4, -1, -1};
        vecs[2] = '{1, 0, 0,  0, 0,  0, 0, 1, 4,  6, -1};
        // Stuck busy: 1 cycle in WAIT_BUSY plus TO cycles of wait.
        vecs[3] = '{2, 0, 0,  0, 0,  0, 1, 0, 0, -1, 1 + TO};
        vecs[4] = '{0, 1, 20, 0, 0,  0, 0, 1, 4, -1, -1};
        vecs[5] = '{0, 1, 20, 0, 0,  3, 0, 1, 4, -1, -1};
        vecs[6] = '{0, 1, 20, 0, 0, 28, 0, 1, 4, -1, -1};
        vecs[7] = '{3, 1, 20, 0, 0,  0, 0, 1, 4, -1, -1};
        vecs[8] = '{1, 0, 0,  2, 0,  0, 0, 1, 4, -1, -1};

        reset = 1'b1;
        start = 1'b0;
        rb_n = 1'b1;
        data_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst CEx", int'(CEx), 1);
        check("rst REx", int'(REx), 1);
        check("rst data_out", int'(data_out), 0);
        check("rst data_valid", int'(data_valid), 0);
        check("rst byte_cnt", int'(byte_cnt), 0);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst error", int'(error), 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            w = $urandom_range(0, 2);
            rv = '{(w == 2) ? 3 : w, $urandom_range(1, 3), $urandom_range(5, 30),
                   $urandom_range(0, 2), $urandom_range(1, 12), 0, 0, 1, 4, -1, -1};
            run_vec(rv, $sformatf("rand%0d", i));
        end

        // Reset during the second RE# low phase.
        for (int i = 0; i < int'(PB); i++) page[i] = 8'($urandom);
        rb_n = 1'b1;
        data_ready = 1'b1;
        fidx = 0;
        clear_mon();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (!(lowruns.size() == 1 && !REx) && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check("midrst reached_2nd_re", int'(w < 100), 1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst REx", int'(REx), 1);
        check("midrst CEx", int'(CEx), 1);
        check("midrst data_valid", int'(data_valid), 0);
        check("midrst byte_cnt", int'(byte_cnt), 0);
        check("midrst busy", int'(busy), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_vec(vecs[0], "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
